// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for a DDS phase accumulator: steps a frequency word
// from F_start toward F_stop in single, sawtooth or triangle fashion, holding each value for Dwell cycles.
module dds_sweep_ctrl #(
  parameter int FW = 32,
  parameter int DW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Stop,
  input  logic [1:0]    Mode,
  input  logic [FW-1:0] F_start,
  input  logic [FW-1:0] F_stop,
  input  logic [FW-1:0] F_step,
  input  logic [DW-1:0] Dwell,
  output logic [FW-1:0] Fword,
  output logic          Busy,
  output logic          Step_stb,
  output logic          Done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UP     = 2'd1,
    DOWN   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] fword_q, fword_d;
  logic          stb_q, stb_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic [FW-1:0] start_q, start_d;
  logic [FW-1:0] stop_q, stop_d;
  logic [FW-1:0] step_q, step_d;
  logic [DW-1:0] dwell_q, dwell_d;

  logic [FW:0]   inc_sum, dec_diff;
  logic [FW-1:0] inc_val, dec_val;
  logic [DW-1:0] dwell_reload, start_reload;
  logic          at_top, at_bottom, tri_mode, saw_mode, tick;

  // Sums and differences carry an extra bit so the clamp sees overflow/underflow instead of a wrap.
  assign inc_sum  = {1'b0, fword_q} + {1'b0, step_q};
  assign dec_diff = {1'b0, fword_q} - {1'b0, step_q};
  assign inc_val  = (inc_sum >= {1'b0, stop_q}) ? stop_q : inc_sum[FW-1:0];
  assign dec_val  = (dec_diff[FW] || (dec_diff[FW-1:0] <= start_q)) ? start_q : dec_diff[FW-1:0];

  assign dwell_reload = (dwell_q == '0) ? '0 : dwell_q - DW'(1);
  assign start_reload = (Dwell == '0) ? '0 : Dwell - DW'(1);

  assign at_top    = (fword_q >= stop_q);
  assign at_bottom = (fword_q <= start_q);
  // A degenerate range makes triangle mode collapse to a single sweep.
  assign tri_mode  = (mode_q == 2'd2) && (start_q < stop_q);
  assign saw_mode  = (mode_q == 2'd1);
  assign tick      = (cnt_q == '0) && (step_q != '0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      fword_q <= '0;
      stb_q   <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= '0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      fword_q <= fword_d;
      stb_q   <= stb_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (Start && !Stop) state_d = UP;
      end
      UP: begin
        if (Stop)                                   state_d = IDLE;
        else if (tick && at_top && tri_mode)        state_d = DOWN;
        else if (tick && at_top && !saw_mode)       state_d = FINISH;
      end
      DOWN: begin
        if (Stop)                      state_d = IDLE;
        else if (tick && at_bottom)    state_d = UP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fword_d = fword_q;
    stb_d   = 1'b0;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    start_d = start_q;
    stop_d  = stop_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    case (state_q)
      IDLE: begin
        if (Start && !Stop) begin
          mode_d  = Mode;
          start_d = F_start;
          stop_d  = F_stop;
          step_d  = F_step;
          dwell_d = Dwell;
          fword_d = F_start;
          stb_d   = 1'b1;
          cnt_d   = start_reload;
        end
      end
      UP, DOWN: begin
        // A zero step freezes the sweep on F_start until Stop or Reset.
        if (!Stop && (step_q != '0)) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DW'(1);
          end else begin
            cnt_d = dwell_reload;
            if (state_q == DOWN)  fword_d = at_bottom ? inc_val : dec_val;
            else if (!at_top)     fword_d = inc_val;
            else if (tri_mode)    fword_d = dec_val;
            else if (saw_mode)    fword_d = start_q;
            stb_d = (fword_d != fword_q);
          end
        end
      end
      default: ;
    endcase
  end

  assign Fword    = fword_q;
  assign Step_stb = stb_q;
  assign Busy     = (state_q == UP) || (state_q == DOWN);
  assign Done     = (state_q == FINISH);

endmodule
